// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: memory-wait, halt and fault sequencing,
// combinational freeze/flush decode and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             halt_req_i,
    output logic             pc_freeze_o,
    output logic             if_freeze_o,
    output logic             if_flush_o,
    output logic             id_flush_o,
    output logic             pipe_freeze_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // state      | meaning
    // S_RUN      | normal flow, hazard/branch handling active
    // S_MEM_WAIT | data memory access outstanding
    // S_HALT     | debug halt, whole pipe frozen
    // S_FAULT    | memory timeout, frozen until reset

    // One spare count above MAX_WAIT so the increment on the fault edge cannot wrap.
    localparam int WC_W = $clog2(MAX_WAIT + 2);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_HALT,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_stall;
    logic              freeze_all;

    always_comb begin
        mem_stall  = ((state_q == S_RUN) && mem_req_i && !mem_ready_i)
                   || ((state_q == S_MEM_WAIT) && !mem_ready_i);
        freeze_all = mem_stall || (state_q == S_HALT) || (state_q == S_FAULT);

        pipe_freeze_o = freeze_all;
        // A hazard under a taken branch is flushed away, so it must not freeze.
        pc_freeze_o   = freeze_all || (hazard_i && !branch_taken_i);
        if_freeze_o   = pc_freeze_o;
        if_flush_o    = branch_taken_i && !freeze_all;
        id_flush_o    = !freeze_all && (branch_taken_i || hazard_i);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            S_RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else if (halt_req_i) begin
                    state_d = S_HALT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = halt_req_i ? S_HALT : S_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_q == WC_W'(MAX_WAIT)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_HALT: begin
                if (!halt_req_i) begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_freeze_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted_o    = (state_q == S_HALT);
    assign fault_o     = (state_q == S_FAULT);
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: maximum consecutive memory-stall cycles tolerated before fault.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 hazard  in  1  RAW data hazard detected for the instruction in ID.
REQ-006 branch_taken  in  1  branch resolved taken in EXE this cycle.
REQ-007 mem_req  in  1  MEM stage holds a load or store this cycle.
REQ-008 mem_ready  in  1  data memory completes the access this cycle.
REQ-009 halt_req  in  1  debug halt request, level-sensitive.
REQ-010 pc_freeze  out  1  hold the PC register.
REQ-011 if_freeze  out  1  hold the IF/ID register (drives its freeze input).
REQ-012 if_flush  out  1  clear the IF/ID register (drives its flush input).
REQ-013 id_flush  out  1  insert a bubble into the ID/EXE register.
REQ-014 pipe_freeze  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
REQ-015 halted  out  1  controller is in HALT.
REQ-016 fault  out  1  memory timeout; sticky until reset.
REQ-017 stall_cnt  out  CNT_W  count of cycles with pc_freeze=1.
REQ-018 flush_cnt  out  CNT_W  count of cycles with if_flush=1.

Function
REQ-019 SHALL implement a 4-state FSM: RUN, MEM_WAIT, HALT, FAULT.
REQ-020 RUN: mem_req&!mem_ready -> MEM_WAIT; else halt_req -> HALT; else stay in RUN.
REQ-021 MEM_WAIT: mem_ready -> HALT if halt_req, else RUN; !mem_ready with wait_cnt==MAX_WAIT -> FAULT; else stay in MEM_WAIT.
REQ-022 HALT: !halt_req -> RUN; else stay in HALT.
REQ-023 FAULT: SHALL remain in FAULT until rst.
REQ-024 Internal wait_cnt: set to 1 on the RUN->MEM_WAIT edge; +1 each MEM_WAIT cycle with !mem_ready; cleared otherwise.
REQ-025 mem_stall = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready), combinational.
REQ-026 freeze_all = mem_stall | HALT | FAULT.
REQ-027 pipe_freeze SHALL equal freeze_all.
REQ-028 pc_freeze SHALL equal if_freeze SHALL equal freeze_all | (hazard & !branch_taken).
REQ-029 if_flush SHALL equal branch_taken & !freeze_all.
REQ-030 id_flush SHALL equal !freeze_all & (branch_taken | hazard).
REQ-031 Priority SHALL be memory stall/halt/fault > branch > hazard. A hazard coincident with a taken branch SHALL NOT freeze, because the hazarding instruction is flushed.
REQ-032 The control outputs (REQ-027..REQ-030) SHALL be combinational, with zero-cycle latency from their inputs.
REQ-033 halted SHALL be 1 only in HALT; fault SHALL be 1 only in FAULT; both are decoded from registered state.
REQ-034 stall_cnt SHALL increment on each clock edge where pc_freeze=1 and saturate at all-ones.
REQ-035 flush_cnt SHALL increment on each clock edge where if_flush=1 and saturate at all-ones.
REQ-036 Counters SHALL keep counting in every state, including HALT and FAULT (pc_freeze=1).
REQ-037 hazard, branch_taken and halt_req SHALL NOT alter the state or outputs while mem_stall=1, except through freeze_all.

Reset
REQ-038 On rst=1: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, halted=0, fault=0, immediately and independently of clk.
REQ-039 Reset asserted mid-stall, mid-halt or in FAULT SHALL return the FSM to RUN. With all inputs 0 in reset, every freeze/flush output SHALL read 0.

Verification (MAX_WAIT=4, CNT_W=8)
REQ-040 hazard=1 for 2 cycles, other inputs 0 -> pc_freeze=if_freeze=id_flush=1 for 2 cycles; stall_cnt=2; if_flush=0.
REQ-041 hazard=1 with branch_taken=1 for 1 cycle -> if_flush=id_flush=1, pc_freeze=0; flush_cnt=1, stall_cnt=0.
REQ-042 mem_req=1, mem_ready low 3 cycles then high -> pipe_freeze=1 for exactly 3 cycles; state returns to RUN; fault=0.
REQ-043 mem_req=1, mem_ready held low -> fault=1 after the 5th consecutive not-ready edge; all freezes stay 1; only rst clears fault.
REQ-044 halt_req=1 while MEM_WAIT, then mem_ready=1 -> HALT entered on that edge, halted=1; halt_req=0 -> RUN next edge.
REQ-045 Force stall_cnt to 255 via a long halt -> stays at 255; asynchronous rst mid-halt -> counters 0 and halted=0 without a clock edge.
